regfile_wb_ctrl: RTL and testbench
==================================

Name: regfile_wb_ctrl

Overview:
- Write-side controller for the integer register file: owns the single write port (WE3/A3/WD3) and merges two producers.
- Producer 1: single-cycle ALU results. Producer 2: in-order, variable-latency load data returned by the data cache.
- Tracks outstanding loads in a destination-tag FIFO and exports a per-register busy scoreboard, so decode can stall RAW/WAW hazards on pending loads.

Parameters:
- N_Bits, 32, data width of register write data.
- DEPTH, 4, maximum outstanding loads (power of 2, >=2).

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- ld_issue_valid  in  1  load issued to cache this cycle.
- ld_issue_rd  in  5  destination register of issued load.
- ld_issue_ready  out  1  tag FIFO can accept (count < DEPTH).
- cache_resp_valid  in  1  cache returns load data (in issue order).
- cache_resp_data  in  N_Bits  load data.
- cache_resp_ready  out  1  response consumed this cycle.
- alu_valid  in  1  ALU result available.
- alu_rd  in  5  ALU destination register.
- alu_data  in  N_Bits  ALU result.
- alu_ready  out  1  ALU result consumed this cycle.
- busy  out  32  busy[i]=1 while any pending load targets xi.
- WE3  out  1  register file write enable (registered).
- A3  out  5  register file write address (registered).
- WD3  out  N_Bits  register file write data (registered).

Behaviour:
- Reset (async, rst_n=0):
  - tag FIFO emptied (rd/wr pointers and count = 0).
  - WE3=0, A3=0, WD3=0; busy=0.
  - ld_issue_ready=1, cache_resp_ready=0.
  - Reset asserted mid-operation discards all pending tags. The cache is flushed externally in the same cycle.
- Load issue: a handshake (ld_issue_valid & ld_issue_ready) pushes ld_issue_rd into the FIFO.
  - ld_issue_ready = (count < DEPTH), from registered state only.
  - A pop in the same cycle does NOT make room when full.
- Load response:
  - cache_resp_ready = FIFO non-empty.
  - A handshake pops the head tag and grants the write port to the load.
  - cache_resp_valid with an empty FIFO is a protocol error: ignored, ready stays 0.
- Arbitration, fixed priority, load first:
  - alu_ready = !(cache_resp_valid & cache_resp_ready) & !busy[alu_rd].
  - An ALU write to a register with a pending load stalls (WAW ordering).
- Write port latency: a grant in cycle t produces WE3/A3/WD3 valid during cycle t+1, for exactly one cycle. The register file captures it at the end of t+1.
  - Without a grant in cycle t, WE3=0 in t+1; A3/WD3 hold their last value.
- x0 handling:
  - A load or ALU grant with rd=0 still completes its handshake (the tag is popped), but WE3 stays 0.
  - busy[0] is always 0.
- Scoreboard:
  - busy[i] = OR over valid FIFO entries with tag==i, i!=0. Combinational from FIFO state.
  - Set the cycle after issue; cleared the cycle after the last matching pop.
  - Multiple pending loads to the same rd keep busy set until the youngest pops.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- Full: count==DEPTH → ld_issue_ready=0 until a pop is registered.
- Throughput: one write per cycle. ALU starves while the cache streams back-to-back responses (accepted; the cache bounds burst length).

Decomposition:
- Package riscv_wb_pkg:
  - REG_ADDR_W=5, NUM_REGS=32.
  - typedef wb_req_t {logic we; logic [4:0] rd; logic [N_Bits-1:0] data}.
- Sub-module rd_tag_fifo:
  - Synchronous FIFO, DEPTH x 5 bits.
  - Exposes count, head, and a per-entry valid vector, from which busy is built.
- Top level holds the arbiter, output register and scoreboard OR-reduction.

Test Plan:
- Reset: drive rst_n=0 mid-traffic with 3 loads pending → WE3=0, busy=0, ld_issue_ready=1 immediately; no stale write after release.
- ALU only: alu_valid=1, rd=5, data=0xDEADBEEF at cycle t → alu_ready=1 at t; WE3=1, A3=5, WD3=0xDEADBEEF at t+1 only.
- Load ordering and WAW stall:
  - Issue loads to x7 then x9 → busy[7]=busy[9]=1.
  - ALU rd=7 held: alu_ready=0.
  - Responses 0x11, 0x22 → writes (7,0x11), then (9,0x22) on consecutive cycles.
  - busy[7] clears, then ALU rd=7 writes.
- Collision: cache_resp_valid and alu_valid in the same cycle (ALU rd=3, not busy) → load written first; alu_ready=0 that cycle; ALU written next cycle.
- Full FIFO: issue DEPTH=4 loads → ld_issue_ready=0. A 5th issue is held through the cycle of the first pop. It is accepted the following cycle, and count never exceeds 4.
- x0: load rd=0 with response 0xFFFF → cache_resp_ready=1, tag popped, WE3 stays 0, busy[0]=0; ALU rd=0 → alu_ready=1, WE3=0.

Source files
------------

// File: rtl/riscv_wb_pkg.sv
// rtl/riscv_wb_pkg.sv - shared types and constants for the register-file write-back controller
// Contents:
//   REG_ADDR_W, NUM_REGS : register address width and register count
//   WB_DATA_W            : default write-data width used by wb_req_t
//   wb_req_t             : one write-port request (enable, address, data)
//   is_x0()              : true when a destination is the hard-wired zero register
package riscv_wb_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int NUM_REGS   = 32;
   localparam int WB_DATA_W  = 32;

   typedef struct packed {
      logic                  we;
      logic [REG_ADDR_W-1:0] rd;
      logic [WB_DATA_W-1:0]  data;
   } wb_req_t;

   function automatic logic is_x0(input logic [REG_ADDR_W-1:0] rd);
      return (rd == '0);
   endfunction

endpackage

// File: rtl/rd_tag_fifo.sv
// rtl/rd_tag_fifo.sv - in-order FIFO of destination tags for outstanding loads
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push, tag_in: write tag_in at the tail (caller guarantees not full)
//   pop         : drop the head entry (caller guarantees not empty)
//   count       : number of valid entries, 0..DEPTH
//   head        : tag at the head of the queue
//   tags        : all storage slots, slot i at [i*5 +: 5]
//   valid       : per-slot valid flag, derived from rd_ptr and count
module rd_tag_fifo
   import riscv_wb_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push,
   input  logic [REG_ADDR_W-1:0]       tag_in,
   input  logic                        pop,
   output logic [PW:0]                 count,
   output logic [REG_ADDR_W-1:0]       head,
   output logic [DEPTH*REG_ADDR_W-1:0] tags,
   output logic [DEPTH-1:0]            valid
);

   logic [REG_ADDR_W-1:0] mem [DEPTH];
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
   end

   // Storage needs no reset: slots are only observed through valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= tag_in;
   end

   assign head = mem[rd_ptr];

   // A slot is live when its distance from the head is below count.
   always_comb begin
      logic [PW-1:0] offset;
      valid = '0;
      tags  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         offset   = PW'(i) - rd_ptr;
         valid[i] = ({1'b0, offset} < count);
         tags[i*REG_ADDR_W +: REG_ADDR_W] = mem[i];
      end
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - single write-port owner merging ALU results and in-order load returns
// Ports:
//   clk, rst_n                         : clock, asynchronous active-low reset
//   ld_issue_valid/rd/ready            : load issue handshake, pushes destination tag
//   cache_resp_valid/data/ready        : load data return, pops head tag, wins the write port
//   alu_valid/rd/data/ready            : ALU result, lower priority, stalls on busy destination
//   busy                               : per-register pending-load scoreboard (bit 0 always 0)
//   WE3, A3, WD3                       : registered register-file write port
module regfile_wb_ctrl
   import riscv_wb_pkg::*;
#(
   parameter int N_Bits = 32,
   parameter int DEPTH  = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  ld_issue_valid,
   input  logic [REG_ADDR_W-1:0] ld_issue_rd,
   output logic                  ld_issue_ready,
   input  logic                  cache_resp_valid,
   input  logic [N_Bits-1:0]     cache_resp_data,
   output logic                  cache_resp_ready,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [N_Bits-1:0]     alu_data,
   output logic                  alu_ready,
   output logic [NUM_REGS-1:0]   busy,
   output logic                  WE3,
   output logic [REG_ADDR_W-1:0] A3,
   output logic [N_Bits-1:0]     WD3
);

   localparam int PW = $clog2(DEPTH);

   logic [PW:0]                 count;
   logic [REG_ADDR_W-1:0]       head;
   logic [DEPTH*REG_ADDR_W-1:0] tags;
   logic [DEPTH-1:0]            valid;
   logic                        ld_push;
   logic                        ld_hs;
   logic                        alu_hs;

   // Readiness comes from registered count only, so a same-cycle pop
   // never opens a slot in a full FIFO.
   assign ld_issue_ready   = (count < (PW+1)'(DEPTH));
   assign cache_resp_ready = (count != '0);

   assign ld_push = ld_issue_valid & ld_issue_ready;
   assign ld_hs   = cache_resp_valid & cache_resp_ready;

   // Load data has priority; an ALU write behind a pending load to the
   // same register must wait so the older load cannot overwrite it.
   assign alu_ready = !ld_hs & !busy[alu_rd];
   assign alu_hs    = alu_valid & alu_ready;

   rd_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (ld_push),
      .tag_in (ld_issue_rd),
      .pop    (ld_hs),
      .count  (count),
      .head   (head),
      .tags   (tags),
      .valid  (valid)
   );

   always_comb begin
      busy = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (valid[i]) busy[tags[i*REG_ADDR_W +: REG_ADDR_W]] = 1'b1;
      end
      busy[0] = 1'b0;
   end

   // Address/data follow every grant; the enable is suppressed for x0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         WE3 <= 1'b0;
         A3  <= '0;
         WD3 <= '0;
      end else if (ld_hs) begin
         WE3 <= !is_x0(head);
         A3  <= head;
         WD3 <= cache_resp_data;
      end else if (alu_hs) begin
         WE3 <= !is_x0(alu_rd);
         A3  <= alu_rd;
         WD3 <= alu_data;
      end else begin
         WE3 <= 1'b0;
      end
   end

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// tb/tb_regfile_wb_ctrl.sv - scoreboard bench for regfile_wb_ctrl
module tb_regfile_wb_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ld_issue_valid;
   logic [4:0]  ld_issue_rd;
   logic        ld_issue_ready;
   logic        cache_resp_valid;
   logic [31:0] cache_resp_data;
   logic        cache_resp_ready;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        alu_ready;
   logic [31:0] busy;
   logic        WE3;
   logic [4:0]  A3;
   logic [31:0] WD3;

   int vectors;
   int miscompares;
   logic [36:0] exp_q[$];

   regfile_wb_ctrl #(.N_Bits(32), .DEPTH(4)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .ld_issue_valid   (ld_issue_valid),
      .ld_issue_rd      (ld_issue_rd),
      .ld_issue_ready   (ld_issue_ready),
      .cache_resp_valid (cache_resp_valid),
      .cache_resp_data  (cache_resp_data),
      .cache_resp_ready (cache_resp_ready),
      .alu_valid        (alu_valid),
      .alu_rd           (alu_rd),
      .alu_data         (alu_data),
      .alu_ready        (alu_ready),
      .busy             (busy),
      .WE3              (WE3),
      .A3               (A3),
      .WD3              (WD3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
      exp_q.push_back({a, d});
   endtask

   // Monitor: every write-port pulse must match the oldest expected write.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && WE3 === 1'b1) begin
         vectors++;
         if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_write: got A3=%0d WD3=0x%08h expected no write", A3, WD3);
         end else begin
            logic [36:0] e;
            e = exp_q.pop_front();
            if ({A3, WD3} !== e) begin
               miscompares++;
               $display("FAIL write: got A3=%0d WD3=0x%08h expected A3=%0d WD3=0x%08h",
                        A3, WD3, e[36:32], e[31:0]);
            end
         end
      end
   end

   initial begin
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      ld_issue_valid = 1'b0;
      ld_issue_rd = '0;
      cache_resp_valid = 1'b0;
      cache_resp_data = '0;
      alu_valid = 1'b0;
      alu_rd = '0;
      alu_data = '0;
      cyc();
      cyc();
      rst_n = 1'b1;
      #1;
      chk("reset_we3", {31'b0, WE3}, 32'd0);
      chk("reset_busy", busy, 32'd0);
      chk("reset_issue_ready", {31'b0, ld_issue_ready}, 32'd1);
      chk("reset_resp_ready", {31'b0, cache_resp_ready}, 32'd0);

      // ALU only
      alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
      #1 chk("alu_only_ready", {31'b0, alu_ready}, 32'd1);
      expect_wr(5'd5, 32'hDEADBEEF);
      cyc();
      alu_valid = 1'b0;
      cyc();

      // Load ordering and WAW stall
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd7;
      #1 chk("issue7_ready", {31'b0, ld_issue_ready}, 32'd1);
      cyc();
      ld_issue_rd = 5'd9;
      cyc();
      ld_issue_valid = 1'b0;
      #1 chk("busy_7_9", busy, 32'h0000_0280);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'h77;
      #1 chk("alu7_stalled", {31'b0, alu_ready}, 32'd0);
      cyc();
      cache_resp_valid = 1'b1; cache_resp_data = 32'h11;
      #1 chk("resp_ready_1", {31'b0, cache_resp_ready}, 32'd1);
      chk("alu7_stall_resp", {31'b0, alu_ready}, 32'd0);
      expect_wr(5'd7, 32'h11);
      cyc();
      cache_resp_data = 32'h22;
      #1 chk("busy7_cleared", busy, 32'h0000_0200);
      chk("alu7_lost_to_load", {31'b0, alu_ready}, 32'd0);
      expect_wr(5'd9, 32'h22);
      cyc();
      cache_resp_valid = 1'b0;
      #1 chk("alu7_granted", {31'b0, alu_ready}, 32'd1);
      expect_wr(5'd7, 32'h77);
      cyc();
      alu_valid = 1'b0;
      cyc();

      // Collision: load and ALU in the same cycle
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd12;
      cyc();
      ld_issue_valid = 1'b0;
      cache_resp_valid = 1'b1; cache_resp_data = 32'hAAAA;
      alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h3333;
      #1 chk("collide_alu_ready", {31'b0, alu_ready}, 32'd0);
      expect_wr(5'd12, 32'hAAAA);
      cyc();
      cache_resp_valid = 1'b0;
      #1 chk("collide_alu_next", {31'b0, alu_ready}, 32'd1);
      expect_wr(5'd3, 32'h3333);
      cyc();
      alu_valid = 1'b0;
      cyc();

      // Full FIFO
      ld_issue_valid = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         ld_issue_rd = 5'(i);
         cyc();
      end
      ld_issue_rd = 5'd5;
      #1 chk("full_ready0", {31'b0, ld_issue_ready}, 32'd0);
      chk("full_busy", busy, 32'h0000_001E);
      cyc();
      cache_resp_valid = 1'b1; cache_resp_data = 32'h101;
      #1 chk("full_pop_no_room", {31'b0, ld_issue_ready}, 32'd0);
      expect_wr(5'd1, 32'h101);
      cyc();
      cache_resp_valid = 1'b0;
      #1 chk("full_room_after_pop", {31'b0, ld_issue_ready}, 32'd1);
      cyc();
      ld_issue_valid = 1'b0;
      #1 chk("full_again", {31'b0, ld_issue_ready}, 32'd0);
      chk("full_busy2", busy, 32'h0000_003C);
      cache_resp_valid = 1'b1;
      for (int i = 2; i <= 5; i++) begin
         cache_resp_data = 32'(i * 32'h101);
         expect_wr(5'(i), 32'(i * 32'h101));
         cyc();
      end
      cache_resp_valid = 1'b0;
      #1 chk("drained_busy", busy, 32'd0);
      chk("drained_resp_ready", {31'b0, cache_resp_ready}, 32'd0);
      cyc();

      // x0 handling
      ld_issue_valid = 1'b1; ld_issue_rd = 5'd0;
      cyc();
      ld_issue_valid = 1'b0;
      #1 chk("x0_busy", busy, 32'd0);
      chk("x0_resp_ready", {31'b0, cache_resp_ready}, 32'd1);
      cache_resp_valid = 1'b1; cache_resp_data = 32'hFFFF;
      cyc();
      cache_resp_valid = 1'b0;
      #1 chk("x0_popped", {31'b0, cache_resp_ready}, 32'd0);
      alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h1234;
      #1 chk("x0_alu_ready", {31'b0, alu_ready}, 32'd1);
      cyc();
      alu_valid = 1'b0;
      cyc();
      cyc();

      // Reset mid-traffic with three loads pending
      ld_issue_valid = 1'b1;
      ld_issue_rd = 5'd6;  cyc();
      ld_issue_rd = 5'd8;  cyc();
      ld_issue_rd = 5'd10; cyc();
      ld_issue_valid = 1'b0;
      #1 chk("pre_reset_busy", busy, 32'h0000_0540);
      alu_valid = 1'b1; alu_rd = 5'd13; alu_data = 32'hBAD0;
      #1 rst_n = 1'b0;
      #1 chk("midreset_we3", {31'b0, WE3}, 32'd0);
      chk("midreset_busy", busy, 32'd0);
      chk("midreset_issue_ready", {31'b0, ld_issue_ready}, 32'd1);
      chk("midreset_resp_ready", {31'b0, cache_resp_ready}, 32'd0);
      alu_valid = 1'b0;
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      cyc();
      chk("post_reset_busy", busy, 32'd0);

      chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
